bootrom_stream_loader: RTL and testbench
========================================

Name: bootrom_stream_loader

Overview:
- Writes the CGB boot ROM image into the boot ROM dual-port RAM's write port (address_b/data_b/wren_b) at power-up or on request from the ESP32 side.
- Accepts a byte stream through a valid/ready handshake, writes bytes sequentially from address 0, counts them and reports busy/done/error status.
- Sits directly upstream of the boot ROM RAM; the emulator core holds the CPU in reset until `done` is high.

Parameters:
- ADDR_W, 12, width of the RAM write address; must match the RAM's addr_widthB.
- DATA_W, 8, width of a stream byte and of the RAM write data.
- IMG_LEN, 2304, number of image bytes written; the last address written is IMG_LEN-1.
- TIMEOUT, 65535, idle cycles allowed between accepted bytes in LOAD before an error.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- abort  in  1  single-cycle pulse; cancels a load in progress.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- address_b  out  ADDR_W  RAM write address.
- data_b  out  DATA_W  RAM write data.
- wren_b  out  1  RAM write strobe, one cycle per byte.
- busy  out  1  a load is in progress.
- done  out  1  the image is loaded; stays high until the next start or reset.
- error  out  1  the load failed (timeout, abort, or checksum); stays high until the next start or reset.
- byte_count  out  ADDR_W+1  bytes accepted in the current or last load.

Behaviour:
- States are IDLE, LOAD, CHECK and FIN. CHECK is used only when the optional feature is compiled in. FIN latches done or error and then returns to IDLE, so the status flags persist while the FSM sits in IDLE.
- Reset values: all outputs are 0 and the state is IDLE. Reset has the same effect at any point, including mid-load.
- IDLE → LOAD on start:
  - start clears done, error, byte_count, the idle timer and the checksum accumulator.
  - start is ignored while busy.
- In LOAD:
  - in_ready = 1 and busy = 1.
  - A byte is accepted on a cycle where in_valid && in_ready.
  - Write latency: a byte accepted in cycle N produces wren_b = 1 in cycle N+1, with address_b = the byte_count value before the increment and data_b = the accepted byte.
  - wren_b is low in every other cycle. address_b and data_b hold their last values when wren_b is low.
- Counting:
  - byte_count increments on each accept.
  - When the accept that brings byte_count to IMG_LEN occurs, in_ready drops in the next cycle. Without the optional feature the FSM moves to FIN with done = 1.
  - No address beyond IMG_LEN-1 is ever written, so the write address never wraps.
- Timeout:
  - The idle counter resets on every accept and increments otherwise.
  - If it reaches TIMEOUT in LOAD, the FSM moves to FIN with error = 1 and stops accepting bytes. Bytes already written stay in RAM.
- Abort:
  - abort in LOAD or CHECK → FIN with error = 1 in the next cycle.
  - abort has priority over a same-cycle accept; that byte is not written.
  - abort outside LOAD and CHECK is ignored.
- start and abort in the same cycle while in IDLE: start wins.
- busy = 1 in LOAD and CHECK, 0 otherwise. done and error are never both 1.

Optional Feature:
- Macro: BOOTLOAD_CSUM_EN.
- With the macro defined:
  - The stream is IMG_LEN+1 bytes. The final byte is a checksum and is not written to RAM (wren_b stays 0 for it).
  - An 8-bit additive sum (mod 256) of the IMG_LEN image bytes plus the checksum byte must equal 0x00.
  - After the checksum byte is accepted, the FSM spends one cycle in CHECK, then goes to FIN with done = 1 on a match or error = 1 on a mismatch.
  - byte_count ends at IMG_LEN+1.
- Without the macro: there is no CHECK state, no accumulator and no trailing byte; completion follows IMG_LEN accepts as described under Behaviour.

Test Plan:
- Reset, then pulse start and stream 2304 bytes where byte i = i[7:0] with in_valid held high → 2304 wren_b pulses; address 0x8FF carries data 0xFF; done = 1 one cycle after the last accept; byte_count = 2304; in_ready = 0 afterwards.
- Toggle in_valid pseudo-randomly during a load → the RAM image matches the full stream; wren_b is never asserted for two writes to the same address.
- Run with TIMEOUT = 100 and stall after 10 bytes → error = 1 exactly 100 idle cycles after the 10th accept; byte_count = 10; done = 0.
- Pulse abort in the same cycle as accepting byte 5 → error = 1 and no wren_b for byte 5; then pulse start → error clears, busy = 1, byte_count = 0.
- Assert reset for one cycle at byte 1000 → all outputs 0, state IDLE, no further writes; a subsequent start and full stream gives done = 1.
- With BOOTLOAD_CSUM_EN: an all-0x01 image has sum 0x00 (2304 mod 256 = 0), so checksum 0x00 → done = 1 and byte_count = 2305. The same image with checksum 0x01 → error = 1. Address 0x900 is never written.

Source files
------------

// File: rtl/bootrom_stream_loader.sv
// Boot ROM stream loader: takes a valid/ready byte stream and writes it into the boot ROM RAM write port.
// Define BOOTLOAD_CSUM_EN to expect a trailing checksum byte and check it in a CHECK state.
`timescale 1ns/1ps
module bootrom_stream_loader #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int IMG_LEN = 2304,
    parameter int TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_b,
    output logic              wren_b,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
`ifdef BOOTLOAD_CSUM_EN
    localparam int STREAM_LEN = IMG_LEN + 1;
`else
    localparam int STREAM_LEN = IMG_LEN;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;
    logic              last_accept;
    logic              img_byte;
`ifdef BOOTLOAD_CSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready depends
    // only on state, never on in_valid; a same-cycle abort squashes the transfer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idle_d      = idle_q;
        done_d      = done_q;
        error_d     = error_q;
        wren_d      = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef BOOTLOAD_CSUM_EN
        sum_d       = sum_q;
`endif
        in_ready    = (state_q == S_LOAD);
        busy        = (state_q == S_LOAD) || (state_q == S_CHECK);
        accept      = in_valid && in_ready && !abort;
        last_accept = accept && (count_q == CNT_W'(STREAM_LEN - 1));
        img_byte    = (count_q < CNT_W'(IMG_LEN));

        case (state_q)
            S_IDLE, S_FIN: begin
                if (state_q == S_FIN) state_d = S_IDLE;
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    idle_d  = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef BOOTLOAD_CSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_FIN;
                    error_d = 1'b1;
                end else if (accept) begin
                    count_d = count_q + 1'b1;
                    idle_d  = '0;
`ifdef BOOTLOAD_CSUM_EN
                    sum_d   = sum_q + 8'(in_data);
`endif
                    // The checksum byte is counted but never reaches the RAM.
                    if (img_byte) begin
                        wren_d = 1'b1;
                        addr_d = count_q[ADDR_W-1:0];
                        data_d = in_data;
                    end
                    if (last_accept) begin
`ifdef BOOTLOAD_CSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_FIN;
                        done_d  = 1'b1;
`endif
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    error_d = 1'b1;
                    idle_d  = idle_q + 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_FIN;
                if (abort) error_d = 1'b1;
`ifdef BOOTLOAD_CSUM_EN
                else if (sum_q == 8'h00) done_d = 1'b1;
                else error_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef BOOTLOAD_CSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            error_q <= error_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef BOOTLOAD_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign address_b  = addr_q;
    assign data_b     = data_q;
    assign wren_b     = wren_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_bootrom_stream_loader.sv
// Directed bench for bootrom_stream_loader: full loads, random valid gaps, timeout, abort, reset, checksum.
`timescale 1ns/1ps
module tb_bootrom_stream_loader;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int IMG_LEN = 2304;
    localparam int TO      = 100;
`ifdef BOOTLOAD_CSUM_EN
    localparam int STREAM_N = IMG_LEN + 1;
`else
    localparam int STREAM_N = IMG_LEN;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] data_b;
    logic              wren_b;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [7:0] mem [0:4095];
    int wr_cnt [0:4095];
    int wr_total = 0;
    int dup_wr   = 0;
    int oob_wr   = 0;

    bootrom_stream_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_LEN(IMG_LEN), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b),
        .busy(busy), .done(done), .error(error), .byte_count(byte_count)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int mode, input int i, input logic [7:0] csum);
        if (i == IMG_LEN) return csum;
        if (mode == 0) return 8'(i);
        return 8'h01;
    endfunction

    // Write monitor: each expected write must appear exactly one cycle after its accept
    always @(negedge clock) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (wren_b || exp_q.size() != 0) begin
            check_eq("wr_strobe", 32'(wren_b), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (wren_b) begin
                    check_eq("wr_addr", 32'(address_b), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check_eq("wr_data", 32'(data_b), 32'(e[DATA_W-1:0]));
                end
            end
            if (wren_b) begin
                if (wr_cnt[address_b] != 0) dup_wr++;
                if (address_b >= ADDR_W'(IMG_LEN)) oob_wr++;
                wr_cnt[address_b]++;
                mem[address_b] = data_b;
                wr_total++;
            end
        end
    end

    // Drivers
    task automatic clear_model();
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'h00;
            wr_cnt[i] = 0;
        end
        wr_total = 0;
        dup_wr   = 0;
        oob_wr   = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_count", 32'(byte_count), 32'd0);
        check_eq("start_flags", {30'd0, done, error}, 32'd0);
    endtask

    task automatic stream(input int n, input int mode, input logic [7:0] csum, input bit rnd);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < n && cyc < 20000) begin
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = byte_of(mode, idx, csum);
            @(negedge clock);
            hs = in_valid && in_ready;
            @(posedge clock); #1;
            if (hs) begin
                if (idx < IMG_LEN) exp_q.push_back({ADDR_W'(idx), in_data});
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("stream_len", idx, n);
    endtask

    task automatic expect_end(input bit exp_done);
`ifdef BOOTLOAD_CSUM_EN
        check_eq("check_busy", 32'(busy), 32'd1);
        check_eq("check_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
`endif
        check_eq("end_done", 32'(done), 32'(exp_done));
        check_eq("end_error", 32'(error), 32'(!exp_done));
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check_eq("hold_done", 32'(done), 32'(exp_done));
        check_eq("hold_error", 32'(error), 32'(!exp_done));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_flags"}, {29'd0, busy, done, error}, 32'd0);
        check_eq({tag, "_count"}, 32'(byte_count), 32'd0);
        check_eq({tag, "_wr"}, {11'd0, wren_b, address_b, data_b}, 32'd0);
    endtask

    task automatic check_image(input int mode);
        int bad = 0;
        for (int i = 0; i < IMG_LEN; i++)
            if (mem[i] !== byte_of(mode, i, 8'h00) || wr_cnt[i] != 1) bad++;
        check_eq("image", bad, 0);
        check_eq("dup_write", dup_wr, 0);
        check_eq("oob_write", oob_wr, 0);
        check_eq("wr_total", wr_total, IMG_LEN);
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Full load, i[7:0] pattern, valid held high (checksum of this image is 0x80)
        clear_model();
        pulse_start();
        stream(STREAM_N, 0, 8'h80, 1'b0);
        expect_end(1'b1);
        check_eq("t1_count", 32'(byte_count), STREAM_N);
        check_eq("t1_mem8ff", 32'(mem[12'h8FF]), 32'hFF);
        check_image(0);

        // Full load with random valid gaps
        clear_model();
        pulse_start();
        stream(STREAM_N, 0, 8'h80, 1'b1);
        expect_end(1'b1);
        check_image(0);

        // Stall after 10 bytes: error exactly TO idle cycles after the 10th accept
        clear_model();
        pulse_start();
        stream(10, 0, 8'h00, 1'b0);
        repeat (TO - 1) @(posedge clock);
        #1;
        check_eq("to_early_err", 32'(error), 32'd0);
        check_eq("to_early_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        check_eq("to_error", 32'(error), 32'd1);
        check_eq("to_done", 32'(done), 32'd0);
        check_eq("to_busy", 32'(busy), 32'd0);
        check_eq("to_count", 32'(byte_count), 32'd10);
        check_eq("to_wr_total", wr_total, 10);

        // Start ignored while busy, then abort on the cycle byte 5 is offered
        clear_model();
        pulse_start();
        stream(5, 0, 8'h00, 1'b0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("busy_start_count", 32'(byte_count), 32'd5);
        check_eq("busy_start_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h05;
        abort    = 1'b1;
        @(posedge clock); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("ab_error", 32'(error), 32'd1);
        check_eq("ab_done", 32'(done), 32'd0);
        check_eq("ab_busy", 32'(busy), 32'd0);
        check_eq("ab_count", 32'(byte_count), 32'd5);
        @(posedge clock); #1;
        check_eq("ab_wr_total", wr_total, 5);
        pulse_start();
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_eq("ab2_error", 32'(error), 32'd1);

        // Reset in the middle of a load, then a full load
        clear_model();
        pulse_start();
        stream(1000, 0, 8'h00, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("midrst");
        in_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_eq("midrst_wr_total", wr_total, 1000);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        clear_model();
        pulse_start();
        stream(STREAM_N, 0, 8'h80, 1'b0);
        expect_end(1'b1);
        check_image(0);

        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", 32'(busy), 32'd1);
        check_eq("sa_flags", {30'd0, done, error}, 32'd0);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_eq("sa_abort_err", 32'(error), 32'd1);

`ifdef BOOTLOAD_CSUM_EN
        // All-0x01 image sums to 0x00, so checksum 0x00 passes and 0x01 fails
        clear_model();
        pulse_start();
        stream(STREAM_N, 1, 8'h00, 1'b0);
        expect_end(1'b1);
        check_eq("cs_ok_count", 32'(byte_count), 32'd2305);
        check_image(1);
        clear_model();
        pulse_start();
        stream(STREAM_N, 1, 8'h01, 1'b0);
        expect_end(1'b0);
        check_eq("cs_bad_count", 32'(byte_count), 32'd2305);
        check_eq("cs_bad_oob", oob_wr, 0);
        check_eq("cs_bad_900", wr_cnt[12'h900], 0);
`endif

        repeat (3) @(posedge clock);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
